ex_muldiv_sequencer: RTL and testbench

//  Iterative multiply/divide unit and its sequencer, beside the EX-stage ALU.

---
 rtl/ex_muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_ex_muldiv_sequencer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ex_muldiv_sequencer.sv
// Iterative radix-2 multiply / restoring-divide unit that owns HI/LO and
// stalls dependent or conflicting EX instructions while an operation runs.
module ex_muldiv_sequencer #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [1:0]        i_op,
    input  logic [DATA_W-1:0] i_operand_a,
    input  logic [DATA_W-1:0] i_operand_b,
    input  logic              i_read_hilo,
    input  logic              i_mthi,
    input  logic              i_mtlo,
    input  logic [DATA_W-1:0] i_mt_data,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_stall
);

    localparam int unsigned CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic                  is_div, sign_a, sign_b, div_zero, done;
    logic [DATA_W-1:0]     opnd, hi, lo;
    logic [2*DATA_W-1:0]   acc;

    logic                  a_neg, b_neg;
    logic [DATA_W-1:0]     mag_a, mag_b;
    logic [DATA_W:0]       mul_add, mul_sum, div_shift, div_diff;
    logic                  div_ge;
    logic [DATA_W-1:0]     div_rem;
    logic [2*DATA_W-1:0]   mul_acc_next, div_acc_next, prod;
    logic [DATA_W-1:0]     quo, rem;
    logic                  neg_res;

    // Signed ops work on magnitudes; the sign is restored in StFix.
    always_comb begin
        a_neg = ~i_op[0] & i_operand_a[DATA_W-1];
        b_neg = ~i_op[0] & i_operand_b[DATA_W-1];
        mag_a = a_neg ? (~i_operand_a + 1'b1) : i_operand_a;
        mag_b = b_neg ? (~i_operand_b + 1'b1) : i_operand_b;
    end

    // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
    always_comb begin
        mul_add      = acc[0] ? {1'b0, opnd} : '0;
        mul_sum      = {1'b0, acc[2*DATA_W-1:DATA_W]} + mul_add;
        mul_acc_next = {mul_sum, acc[DATA_W-1:1]};
        div_shift    = acc[2*DATA_W-1:DATA_W-1];
        div_diff     = div_shift - {1'b0, opnd};
        div_ge       = ~div_diff[DATA_W];
        div_rem      = div_ge ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0];
        div_acc_next = {div_rem, acc[DATA_W-2:0], div_ge};
    end

    // With a zero divisor the remainder path still reproduces a, so only LO needs overriding.
    always_comb begin
        neg_res = sign_a ^ sign_b;
        prod    = neg_res ? (~acc + 1'b1) : acc;
        quo     = div_zero ? '1
                : (neg_res ? (~acc[DATA_W-1:0] + 1'b1) : acc[DATA_W-1:0]);
        rem     = sign_a ? (~acc[2*DATA_W-1:DATA_W] + 1'b1) : acc[2*DATA_W-1:DATA_W];
    end

    always_comb begin
        state_next = state;
        unique case (state)
            StIdle:  if (i_start) state_next = StRun;
            StRun:   if (cnt == CntLast) state_next = StFix;
            StFix:   state_next = StIdle;
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) state <= StIdle;
        else          state <= state_next;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            cnt      <= '0;
            is_div   <= 1'b0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            div_zero <= 1'b0;
            opnd     <= '0;
            acc      <= '0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == StFix);
            unique case (state)
                StIdle: begin
                    if (i_start) begin
                        is_div   <= i_op[1];
                        sign_a   <= a_neg;
                        sign_b   <= b_neg;
                        div_zero <= (i_operand_b == '0);
                        cnt      <= '0;
                        opnd     <= i_op[1] ? mag_b : mag_a;
                        acc      <= {{DATA_W{1'b0}}, (i_op[1] ? mag_a : mag_b)};
                    end else begin
                        if (i_mthi) hi <= i_mt_data;
                        if (i_mtlo) lo <= i_mt_data;
                    end
                end
                StRun: begin
                    cnt <= cnt + 1'b1;
                    acc <= is_div ? div_acc_next : mul_acc_next;
                end
                StFix: begin
                    if (is_div) {hi, lo} <= {rem, quo};
                    else        {hi, lo} <= prod;
                end
                default: ;
            endcase
        end
    end

    assign o_hi    = hi;
    assign o_lo    = lo;
    assign o_busy  = (state != StIdle);
    assign o_done  = done;
    assign o_stall = (state != StIdle) & (i_start | i_read_hilo | i_mthi | i_mtlo);

endmodule

// File: tb/tb_ex_muldiv_sequencer.sv
// Scoreboard bench: stimulus pushes expected {HI,LO}; a monitor pops on o_done.
module tb_ex_muldiv_sequencer;

    localparam int W = 32;
    localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start, read_hilo, mthi, mtlo;
    logic [1:0]   op;
    logic [W-1:0] a, b, mt_data, hi, lo;
    logic         busy, done, stall;

    int errors = 0;
    int checks = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    ex_muldiv_sequencer #(.DATA_W(W)) dut (
        .i_clk       (clk),
        .i_reset     (rst_n),
        .i_start     (start),
        .i_op        (op),
        .i_operand_a (a),
        .i_operand_b (b),
        .i_read_hilo (read_hilo),
        .i_mthi      (mthi),
        .i_mtlo      (mtlo),
        .i_mt_data   (mt_data),
        .o_hi        (hi),
        .o_lo        (lo),
        .o_busy      (busy),
        .o_done      (done),
        .o_stall     (stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                check("hilo_result", {hi, lo}, exp_q.pop_front());
            end
        end
    end

    // Called just after a posedge; holds start until the unit is idle, then releases it.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic [63:0] expv, output int waited, output logic first_stall);
        start = 1'b1; op = o; a = va; b = vb;
        exp_q.push_back(expv);
        waited = 0;
        first_stall = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            waited++;
            if (i == 0) first_stall = stall;
            if (!busy) break;
        end
        if (busy) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        start = 1'b0;
        a = '1; b = '1;  // later operand changes must not matter
    endtask

    task automatic wait_done(output int busy_cycles);
        busy_cycles = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) break;
        end
        if (!done) check("done_timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int n, bc, sc;
        logic fs;
        start = 0; read_hilo = 0; mthi = 0; mtlo = 0; op = 0; a = 0; b = 0; mt_data = 0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {hi, lo}, 64'd0);
        check("reset_flags", {61'd0, busy, done, stall}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1. MULT 7*6, busy length and done pulse width
        issue(OpMult, 32'd7, 32'd6, 64'd42, n, fs);
        wait_done(bc);
        check("mult_busy_cycles", 64'(bc), 64'd33);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        @(posedge clk); #1;

        // 2. signed and unsigned multiply
        issue(OpMult, -32'sd3, 32'd5, 64'hFFFFFFFF_FFFFFFF1, n, fs);
        wait_done(bc);
        @(posedge clk); #1;
        issue(OpMultu, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE_00000001, n, fs);
        wait_done(bc);
        @(posedge clk); #1;

        // 3. divide cases
        issue(OpDiv, -32'sd7, 32'd2, 64'hFFFFFFFF_FFFFFFFD, n, fs);
        wait_done(bc);
        @(posedge clk); #1;
        issue(OpDivu, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, n, fs);
        wait_done(bc);
        @(posedge clk); #1;
        issue(OpDiv, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, n, fs);
        wait_done(bc);
        @(posedge clk); #1;
        issue(OpDiv, -32'sd9, 32'd0, 64'hFFFFFFF7_FFFFFFFF, n, fs);
        wait_done(bc);
        @(posedge clk); #1;

        // 4. MFHI waits for the result
        read_hilo = 1'b1;
        @(negedge clk);
        check("idle_read_no_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        read_hilo = 1'b0;
        issue(OpDivu, 32'd100, 32'd7, 64'h00000002_0000000E, n, fs);
        read_hilo = 1'b1;
        sc = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (stall) sc++;
        end
        check("mfhi_stall_cycles", 64'(sc), 64'd33);
        check("mfhi_stall_released", {63'd0, stall}, 64'd0);
        check("mfhi_hi_value", {32'd0, hi}, 64'd2);
        @(posedge clk); #1;
        read_hilo = 1'b0;

        // 5. back-to-back MULT held in EX
        issue(OpMult, 32'd3, 32'd4, 64'd12, n, fs);
        @(negedge clk);
        check("unrelated_no_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        issue(OpMult, 32'd1000, -32'sd2, 64'hFFFFFFFF_FFFFF830, n, fs);
        check("held_start_stalls", {63'd0, fs}, 64'd1);
        check("accept_first_idle", 64'(n), 64'd33);
        wait_done(bc);
        @(posedge clk); #1;

        // 6. MTLO / MTHI in idle
        mtlo = 1'b1; mt_data = 32'h1234;
        @(negedge clk);
        check("mtlo_no_stall", {63'd0, stall}, 64'd0);
        @(posedge clk); #1;
        mtlo = 1'b0;
        check("mtlo_value", {32'd0, lo}, 64'h1234);
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'hCAFE0001;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mthi_mtlo_both", {hi, lo}, 64'hCAFE0001_CAFE0001);

        // reset in the middle of a DIV
        issue(OpDiv, 32'd1000, 32'd3, 64'h00000001_0000014D, n, fs);
        void'(exp_q.pop_back());
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_hilo", {hi, lo}, 64'd0);
        check("abort_busy", {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(OpDiv, 32'd1000, 32'd3, 64'h00000001_0000014D, n, fs);
        wait_done(bc);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
